// File: rtl/irq_ctrl.sv
// irq_ctrl: 8-source memory-mapped interrupt controller with claim/complete handshake. Optional macro IRQC_SYNC_EN adds a 2-flop synchroniser on irq_src_i.
module irq_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int          NUM_SRC   = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  irq_src_i,
  input  logic        mie_meie_i,
  input  logic [31:0] bus_addr_i,
  input  logic [31:0] bus_data_i,
  input  logic [3:0]  bus_mask_i,
  input  logic        bus_rstb_i,
  output logic [31:0] bus_data_o,
  output logic        irq_master_o,
  output logic [7:0]  irq_bus_o
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t      state, state_nxt;
  logic [7:0]  pending, enable, edge_sel, s, prev, cand, rise, clr, pending_nxt, rdata;
  logic [2:0]  in_service, winner;
  logic [3:0]  claim_val;
  logic [1:0]  off;
  logic        sel, wr, rd, claim, complete;
  logic        unused_bits;
  assign unused_bits = ^{bus_addr_i[1:0], bus_data_i[31:8]};
  assign sel = bus_addr_i[31:4] == BASE_ADDR[31:4];
  assign off = bus_addr_i[3:2];
  assign wr  = sel && |bus_mask_i;
  assign rd  = sel && bus_rstb_i;
`ifdef IRQC_SYNC_EN
  logic [7:0] sync1, sync2;
  // two-stage synchroniser for sources asynchronous to clk_i
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= irq_src_i;
      sync2 <= sync1;
    end
  assign s = sync2;
`else
  assign s = irq_src_i;
`endif
  assign cand = pending & enable;
  assign rise = s & ~prev;
  // fixed priority: lowest-numbered enabled pending source wins
  always_comb begin
    winner    = '0;
    claim_val = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (cand[i]) begin
        winner    = 3'(i);
        claim_val = 4'(i + 1);
      end
  end
  assign claim    = rd && off == 2'd3 && state == IDLE && |cand;
  assign complete = wr && off == 2'd3 && state == BUSY && bus_data_i[3:0] == {1'b0, in_service} + 4'd1;
  assign clr      = (wr && off == 2'd0 ? bus_data_i[7:0] : 8'h00) | (claim ? 8'h01 << winner : 8'h00);
  assign pending_nxt = (edge_sel & ((pending & ~clr) | rise)) | (~edge_sel & s);
  // register read mux; claim reads 0 while an interrupt is in service
  always_comb
    rdata = off == 2'd0 ? pending :
            off == 2'd1 ? enable :
            off == 2'd2 ? edge_sel :
            state == IDLE ? {4'b0, claim_val} : 8'h00;
  // claim moves to BUSY, a matching complete returns to IDLE
  always_comb
    state_nxt = claim ? BUSY : complete ? IDLE : state;
  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= IDLE;
    else state <= state_nxt;
  // source history, pending/config registers, read data and registered irq outputs
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      prev         <= '0;
      pending      <= '0;
      enable       <= '0;
      edge_sel     <= '0;
      in_service   <= '0;
      bus_data_o   <= '0;
      irq_bus_o    <= '0;
      irq_master_o <= 1'b0;
    end else begin
      prev         <= s;
      pending      <= pending_nxt;
      if (wr && off == 2'd1) enable <= bus_data_i[7:0];
      if (wr && off == 2'd2) edge_sel <= bus_data_i[7:0];
      if (claim) in_service <= winner;
      bus_data_o   <= rd ? {24'b0, rdata} : 32'b0;
      irq_bus_o    <= cand;
      irq_master_o <= state == IDLE && mie_meie_i && |cand;
    end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: table-driven check of irq_ctrl register, arbitration and claim/complete behaviour (default build, direct sampling).
module tb_irq_ctrl;
  localparam logic [31:0] BASE = 32'h0200_0000;
  logic        clk = 1'b0, rst = 1'b1, mie = 1'b0, rstb = 1'b0, master;
  logic [7:0]  src = '0, ibus;
  logic [31:0] addr = '0, wdata = '0, rdata;
  logic [3:0]  mask = '0;
  int          nvec = 0, nerr = 0;

  irq_ctrl dut (
    .clk_i(clk), .rst_i(rst), .irq_src_i(src), .mie_meie_i(mie),
    .bus_addr_i(addr), .bus_data_i(wdata), .bus_mask_i(mask), .bus_rstb_i(rstb),
    .bus_data_o(rdata), .irq_master_o(master), .irq_bus_o(ibus)
  );

  always #5 clk = ~clk;

  // op: 0 idle, 1 read, 2 write, 3 read outside the register window
  typedef struct packed {
    logic [1:0] op;
    logic [1:0] off;
    logic [7:0] wd;
    logic [7:0] sr;
    logic       mi;
    logic [7:0] ed;
    logic       em;
    logic [7:0] eb;
  } vec_t;
  vec_t vq[$];

  function automatic vec_t mk(input logic [1:0] op, input logic [1:0] off, input logic [7:0] wd,
                              input logic [7:0] sr, input logic mi, input logic [7:0] ed,
                              input logic em, input logic [7:0] eb);
    mk = '{op, off, wd, sr, mi, ed, em, eb};
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    @(negedge clk);
    addr  = (v.op == 2'd3 ? 32'h0300_0000 : BASE) | {28'b0, v.off, 2'b00};
    rstb  = v.op == 2'd1 || v.op == 2'd3;
    mask  = v.op == 2'd2 ? (v.off[0] ? 4'b1100 : 4'b0001) : 4'b0000;
    wdata = {24'hA5A5A5, v.wd};
    src   = v.sr;
    mie   = v.mi;
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v, input int idx);
    drive(v);
    chk("bus_data_o", idx, rdata, {24'b0, v.ed});
    chk("irq_master_o", idx, {31'b0, master}, {31'b0, v.em});
    chk("irq_bus_o", idx, {24'b0, ibus}, {24'b0, v.eb});
  endtask

  initial begin
    vq.push_back(mk(1, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00));
    vq.push_back(mk(1, 1, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00));
    vq.push_back(mk(1, 2, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00));
    vq.push_back(mk(1, 3, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00));
    vq.push_back(mk(2, 1, 8'h0C, 8'h00, 0, 8'h00, 0, 8'h00));
    vq.push_back(mk(2, 2, 8'h0C, 8'h00, 0, 8'h00, 0, 8'h00));
    vq.push_back(mk(0, 0, 8'h00, 8'h08, 1, 8'h00, 0, 8'h00));
    vq.push_back(mk(0, 0, 8'h00, 8'h00, 1, 8'h00, 1, 8'h08));
    vq.push_back(mk(1, 3, 8'h00, 8'h00, 1, 8'h04, 1, 8'h08));
    vq.push_back(mk(1, 0, 8'h00, 8'h00, 1, 8'h00, 0, 8'h00));
    vq.push_back(mk(2, 3, 8'h04, 8'h00, 1, 8'h00, 0, 8'h00));
    vq.push_back(mk(2, 1, 8'hFF, 8'h00, 1, 8'h00, 0, 8'h00));
    vq.push_back(mk(2, 2, 8'h2C, 8'h00, 1, 8'h00, 0, 8'h00));
    vq.push_back(mk(0, 0, 8'h00, 8'h24, 1, 8'h00, 0, 8'h00));
    vq.push_back(mk(0, 0, 8'h00, 8'h00, 1, 8'h00, 1, 8'h24));
    vq.push_back(mk(1, 3, 8'h00, 8'h00, 1, 8'h03, 1, 8'h24));
    vq.push_back(mk(1, 3, 8'h00, 8'h00, 1, 8'h00, 0, 8'h20));
    vq.push_back(mk(2, 3, 8'h06, 8'h00, 1, 8'h00, 0, 8'h20));
    vq.push_back(mk(1, 3, 8'h00, 8'h00, 1, 8'h00, 0, 8'h20));
    vq.push_back(mk(2, 3, 8'h03, 8'h00, 1, 8'h00, 0, 8'h20));
    vq.push_back(mk(0, 0, 8'h00, 8'h00, 1, 8'h00, 1, 8'h20));
    vq.push_back(mk(1, 3, 8'h00, 8'h00, 1, 8'h06, 1, 8'h20));
    vq.push_back(mk(2, 3, 8'h06, 8'h00, 1, 8'h00, 0, 8'h00));
    vq.push_back(mk(0, 0, 8'h00, 8'h02, 1, 8'h00, 0, 8'h00));
    vq.push_back(mk(0, 0, 8'h00, 8'h02, 1, 8'h00, 1, 8'h02));
    vq.push_back(mk(1, 3, 8'h00, 8'h02, 1, 8'h02, 1, 8'h02));
    vq.push_back(mk(2, 3, 8'h02, 8'h02, 1, 8'h00, 0, 8'h02));
    vq.push_back(mk(0, 0, 8'h00, 8'h02, 1, 8'h00, 1, 8'h02));
    vq.push_back(mk(1, 0, 8'h00, 8'h00, 1, 8'h02, 1, 8'h02));
    vq.push_back(mk(1, 0, 8'h00, 8'h00, 1, 8'h00, 0, 8'h00));
    vq.push_back(mk(2, 2, 8'h2D, 8'h00, 1, 8'h00, 0, 8'h00));
    vq.push_back(mk(2, 0, 8'h01, 8'h01, 0, 8'h00, 0, 8'h00));
    vq.push_back(mk(1, 0, 8'h00, 8'h00, 0, 8'h01, 0, 8'h01));
    vq.push_back(mk(3, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h01));
    vq.push_back(mk(0, 0, 8'h00, 8'h00, 1, 8'h00, 1, 8'h01));
    vq.push_back(mk(2, 0, 8'h01, 8'h00, 1, 8'h00, 1, 8'h01));
    vq.push_back(mk(0, 0, 8'h00, 8'h00, 1, 8'h00, 0, 8'h00));

    repeat (2) @(negedge clk);
    chk("reset irq_master_o", 0, {31'b0, master}, 32'd0);
    chk("reset irq_bus_o", 0, {24'b0, ibus}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) apply(vq[i], i);

    // level source 4 plus edge source 5 pending, claim 4, then reset while BUSY
    apply(mk(0, 0, 8'h00, 8'h30, 1, 8'h00, 0, 8'h00), 100);
    apply(mk(0, 0, 8'h00, 8'h30, 1, 8'h00, 1, 8'h30), 101);
    apply(mk(1, 3, 8'h00, 8'h30, 1, 8'h05, 1, 8'h30), 102);
    apply(mk(0, 0, 8'h00, 8'h30, 1, 8'h00, 0, 8'h30), 103);
    #3;
    rst = 1'b1;
    #1;
    chk("async rst irq_bus_o", 104, {24'b0, ibus}, 32'd0);
    chk("async rst irq_master_o", 104, {31'b0, master}, 32'd0);
    chk("async rst bus_data_o", 104, rdata, 32'd0);
    @(negedge clk);
    src = '0;
    rst = 1'b0;
    apply(mk(1, 3, 8'h00, 8'h00, 1, 8'h00, 0, 8'h00), 105);
    apply(mk(1, 1, 8'h00, 8'h00, 1, 8'h00, 0, 8'h00), 106);
    apply(mk(1, 2, 8'h00, 8'h00, 1, 8'h00, 0, 8'h00), 107);
    apply(mk(2, 1, 8'hFF, 8'h00, 1, 8'h00, 0, 8'h00), 108);
    apply(mk(0, 0, 8'h00, 8'h01, 1, 8'h00, 0, 8'h00), 109);
    apply(mk(0, 0, 8'h00, 8'h01, 1, 8'h00, 1, 8'h01), 110);
    apply(mk(1, 3, 8'h00, 8'h01, 1, 8'h01, 1, 8'h01), 111);
    apply(mk(0, 0, 8'h00, 8'h00, 1, 8'h00, 0, 8'h01), 112);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
